// File: rtl/comms_pkg.sv
// Shared definitions for the AT command transmitter: command indices, FSM state
// encoding and the ASCII line terminators.
package comms_pkg;

    localparam logic [2:0] CMD_AT   = 3'd0;
    localparam logic [2:0] CMD_ATE0 = 3'd1;
    localparam logic [2:0] CMD_CMGF = 3'd2;
    localparam logic [2:0] CMD_CNMI = 3'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_SEND = ST_SEND,
        S_DONE = ST_DONE
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// tx_done pulses during the last clock of the stop bit.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   DONE_CNT = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]      STOP_BIT = 4'd9;

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '1;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (tx_start) begin
                    tx_busy <= 1'b1;
                    tx      <= 1'b0;
                    shift   <= {1'b1, tx_data};
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            end else begin
                // Raised one clock early so the pulse covers the final stop-bit cycle.
                if (bit_cnt == STOP_BIT && clk_cnt == DONE_CNT)
                    tx_done <= 1'b1;
                if (clk_cnt == LAST_CNT) begin
                    clk_cnt <= '0;
                    if (bit_cnt == STOP_BIT) begin
                        tx_busy <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        tx      <= shift[0];
                        shift   <= {1'b1, shift[8:1]};
                    end
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/at_command_tx.sv
// Sends the AT command selected by command_1 as 8N1 UART frames on each rising
// edge of start. Define AT_APPEND_CRLF_EN to append CR LF to every command.
module at_command_tx
    import comms_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] command_1,
    input  logic       start,
    output logic       ready_command,
    output logic       tx
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    state_t     state;
    logic       start_q;
    logic       rise;
    logic [2:0] cmd_q;
    logic [3:0] index;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    logic [2:0] sel_cmd;
    logic [3:0] sel_idx;
    logic [7:0] sel_byte;
    logic       sel_valid;
    logic       cur_valid;

    function automatic logic [3:0] rom_len(input logic [2:0] cmd);
        case (cmd)
            CMD_AT:   rom_len = 4'd2;
            CMD_ATE0: rom_len = 4'd4;
            CMD_CMGF: rom_len = 4'd9;
            CMD_CNMI: rom_len = 4'd11;
            default:  rom_len = 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] rom_char(input logic [2:0] cmd, input logic [3:0] idx);
        rom_char = 8'h00;
        case (cmd)
            CMD_AT:
                case (idx)
                    4'd0: rom_char = "A";
                    4'd1: rom_char = "T";
                    default: ;
                endcase
            CMD_ATE0:
                case (idx)
                    4'd0: rom_char = "A";
                    4'd1: rom_char = "T";
                    4'd2: rom_char = "E";
                    4'd3: rom_char = "0";
                    default: ;
                endcase
            CMD_CMGF:
                case (idx)
                    4'd0: rom_char = "A";
                    4'd1: rom_char = "T";
                    4'd2: rom_char = "+";
                    4'd3: rom_char = "C";
                    4'd4: rom_char = "M";
                    4'd5: rom_char = "G";
                    4'd6: rom_char = "F";
                    4'd7: rom_char = "=";
                    4'd8: rom_char = "1";
                    default: ;
                endcase
            CMD_CNMI:
                case (idx)
                    4'd0:  rom_char = "A";
                    4'd1:  rom_char = "T";
                    4'd2:  rom_char = "+";
                    4'd3:  rom_char = "C";
                    4'd4:  rom_char = "N";
                    4'd5:  rom_char = "M";
                    4'd6:  rom_char = "I";
                    4'd7:  rom_char = "=";
                    4'd8:  rom_char = "2";
                    4'd9:  rom_char = ",";
                    4'd10: rom_char = "2";
                    default: ;
                endcase
            default: ;
        endcase
    endfunction

    function automatic logic [3:0] eff_len(input logic [2:0] cmd);
`ifdef AT_APPEND_CRLF_EN
        eff_len = rom_len(cmd) + 4'd2;
`else
        eff_len = rom_len(cmd);
`endif
    endfunction

    function automatic logic [7:0] eff_char(input logic [2:0] cmd, input logic [3:0] idx);
`ifdef AT_APPEND_CRLF_EN
        if (idx == rom_len(cmd))
            eff_char = ASCII_CR;
        else if (idx == rom_len(cmd) + 4'd1)
            eff_char = ASCII_LF;
        else
            eff_char = rom_char(cmd, idx);
`else
        eff_char = rom_char(cmd, idx);
`endif
    endfunction

    assign rise      = start & ~start_q;
    assign cur_valid = index < eff_len(cmd_q);

    // The next byte is fetched while entering S_LOAD, so tx_start is high during
    // S_LOAD itself and the line idles exactly one clock between frames.
    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        sel_cmd = cmd_q;
        sel_idx = index + 4'd1;
        if (state == S_IDLE) begin
            sel_cmd = command_1;
            sel_idx = 4'd0;
        end
        sel_byte  = eff_char(sel_cmd, sel_idx);
        sel_valid = sel_idx < eff_len(sel_cmd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            start_q       <= 1'b0;
            cmd_q         <= '0;
            index         <= '0;
            tx_start      <= 1'b0;
            tx_data       <= '0;
            ready_command <= 1'b1;
        end else begin
            start_q       <= start;
            tx_start      <= 1'b0;
            // Lags the state by one clock: falls the edge after the rise is taken.
            ready_command <= (state == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (rise && !tx_busy) begin
                        cmd_q <= command_1;
                        index <= 4'd0;
                        state <= S_LOAD;
                        if (sel_valid) begin
                            tx_start <= 1'b1;
                            tx_data  <= sel_byte;
                        end
                    end
                end
                S_LOAD: begin
                    state <= cur_valid ? S_SEND : S_DONE;
                end
                S_SEND: begin
                    if (tx_done) begin
                        index <= index + 4'd1;
                        if (sel_valid) begin
                            state    <= S_LOAD;
                            tx_start <= 1'b1;
                            tx_data  <= sel_byte;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_at_command_tx.sv
// Self-checking bench for at_command_tx: a UART line decoder and a string-level
// command model predict the bytes, frame spacing and ready_command low time.
module tb_at_command_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] command_1 = 3'd0;
    logic       ready_command;
    logic       tx;

    always #5 clk = ~clk;

    at_command_tx #(
        .CLK_HZ(1000),
        .BAUD  (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .command_1    (command_1),
        .start        (start),
        .ready_command(ready_command),
        .tx           (tx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the command text as a string, plus optional CR LF.
    function automatic void model(input int cmd, output logic [7:0] q[$]);
        string s;
        q.delete();
        case (cmd)
            0:       s = "AT";
            1:       s = "ATE0";
            2:       s = "AT+CMGF=1";
            3:       s = "AT+CNMI=2,2";
            default: s = "";
        endcase
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
`ifdef AT_APPEND_CRLF_EN
        q.push_back(8'h0D);
        q.push_back(8'h0A);
`endif
    endfunction

    // n frames of 100 clocks, one idle clock between frames, one S_LOAD before
    // the first and one S_DONE after the last; an empty command costs 2 clocks.
    function automatic int expected_low(input int n);
        return (n == 0) ? 2 : 101 * n + 1;
    endfunction

    // UART decoder: samples the line at the middle of each 10-clock bit.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         now = 0;
    int         tx_low = 0;
    bit         in_frame = 1'b0;
    int         fc = 0;
    logic [7:0] sh = '0;

    always @(negedge clk) begin
        now++;
        if (tx !== 1'b1) tx_low++;
        if (!rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                fc = 0;
                rx_t.push_back(now);
            end
        end else begin
            fc++;
            if (fc == 5)
                check("start_bit", {31'd0, tx}, 32'd0);
            else if (fc % 10 == 5 && fc < 95)
                sh[fc/10-1] = tx;
            else if (fc == 95) begin
                check("stop_bit", {31'd0, tx}, 32'd1);
                rx_q.push_back(sh);
                in_frame = 1'b0;
            end
        end
    end

    task automatic run_cmd(input int cmd, input bit noise, input int glitch_at);
        logic [7:0] exp_q[$];
        int exp_low;
        int low;
        int tx_low0;
        model(cmd, exp_q);
        exp_low = expected_low(exp_q.size());
        rx_q.delete();
        rx_t.delete();
        @(negedge clk);
        tx_low0   = tx_low;
        command_1 = 3'(cmd);
        start     = 1'b1;
        @(negedge clk);
        check($sformatf("ready_before_fall_c%0d", cmd), {31'd0, ready_command}, 32'd1);
        @(negedge clk);
        low = 0;
        while (ready_command === 1'b0 && low < 3000) begin
            low++;
            if (noise && low < exp_low - 5) begin
                command_1 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) start = ~start;
            end
            if (low == glitch_at) start = 1'b0;
            if (low == glitch_at + 3) start = 1'b1;
            @(negedge clk);
        end
        check($sformatf("ready_low_cycles_c%0d", cmd), low, exp_low);
        check($sformatf("byte_count_c%0d", cmd), rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("byte%0d_c%0d", i, cmd), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        for (int i = 1; i < rx_t.size(); i++)
            check($sformatf("frame_gap%0d_c%0d", i, cmd), rx_t[i] - rx_t[i-1], 101);
        if (exp_q.size() == 0)
            check($sformatf("tx_quiet_c%0d", cmd), tx_low - tx_low0, 0);
    endtask

    initial begin
        int bad;
        int w;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_ready", {31'd0, ready_command}, 32'd1);
        rst = 1'b1;

        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready_command !== 1'b1) bad++;
        end
        check("idle_200", bad, 0);

        // Command 0 with start held high afterwards: must not retrigger.
        run_cmd(0, 1'b0, -1);
        rx_q.delete();
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (ready_command !== 1'b1) bad++;
        end
        check("held_start_ready", bad, 0);
        check("held_start_bytes", rx_q.size(), 0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        run_cmd(3, 1'b0, -1);
        start = 1'b0;
        repeat (3) @(negedge clk);

        run_cmd(5, 1'b0, -1);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // A second rising edge in the middle of byte 2 is ignored.
        run_cmd(2, 1'b0, 150);
        rx_q.delete();
        repeat (300) @(negedge clk);
        check("glitch_no_requeue", rx_q.size(), 0);
        check("glitch_ready_after", {31'd0, ready_command}, 32'd1);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset during bit 0 of byte 2 ("T" = 0x54, bit 0 is 0).
        rx_q.delete();
        command_1 = 3'd2;
        start = 1'b1;
        w = 0;
        while (ready_command !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("rst_test_busy", {31'd0, ready_command}, 32'd0);
        repeat (114) @(negedge clk);
        check("rst_test_bytes_before", rx_q.size(), 1);
        check("rst_test_tx_low", {31'd0, tx}, 32'd0);
        #1 rst = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, tx}, 32'd1);
        check("rst_async_ready", {31'd0, ready_command}, 32'd1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        run_cmd(1, 1'b0, -1);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Random commands with command_1 scrambled and start toggled while busy.
        repeat (6) begin
            run_cmd(int'($urandom_range(0, 7)), 1'b1, -1);
            start = 1'b0;
            repeat ($urandom_range(2, 20)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
